// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, filters ROM responses by echoed
// address into a small in-order buffer, and hands {pc, instruction} to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] mem_addr_echo,
  input  logic        mem_read_valid,
  input  logic        mem_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_buf_pc   [DEPTH];
  logic [31:0]      r_buf_data [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_inst_valid;
  logic [31:0]      r_inst_data;
  logic [31:0]      r_inst_pc;

  logic             w_pop;
  logic             w_space;
  logic             w_echo_match;
  logic             w_accept;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_head_is_new;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_data;
  logic             w_unused_bits;

  assign mem_addr   = r_fetch_pc;
  assign inst_valid = r_inst_valid;
  assign inst_data  = r_inst_data;
  assign inst_pc    = r_inst_pc;

  assign w_pop        = r_inst_valid & inst_ready;
  assign w_space      = (r_count < CNT_W'(DEPTH)) | w_pop;
  assign w_echo_match = ({mem_addr_echo[31:2], 2'b00} == r_fetch_pc);
  assign w_accept     = fetch_en & mem_ready & mem_read_valid & w_echo_match
                        & w_space & ~redirect_valid;

  assign w_wptr_nxt  = w_accept ? r_wptr + PTR_W'(1) : r_wptr;
  assign w_rptr_nxt  = w_pop    ? r_rptr + PTR_W'(1) : r_rptr;
  assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

  // The next head is the word being written now when the buffer would otherwise be empty.
  assign w_head_is_new = w_accept & (r_wptr == w_rptr_nxt);
  assign w_head_pc     = w_head_is_new ? r_fetch_pc : r_buf_pc[w_rptr_nxt];
  assign w_head_data   = w_head_is_new ? mem_data   : r_buf_data[w_rptr_nxt];

  assign w_unused_bits = ^{mem_addr_echo[1:0], redirect_pc[1:0]};

  // Buffer storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_pc[r_wptr]   <= r_fetch_pc;
      r_buf_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_inst_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_inst_data <= w_head_data;
        r_inst_pc   <= w_head_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a queue-based reference
// model and a scoreboard monitor that checks every decode handshake.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_data, mem_addr_echo;
  logic        mem_read_valid, mem_ready;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        echo_ovr;
  logic [31:0] echo_val;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  logic [31:0] m_pc;
  logic [63:0] m_buf[$];
  logic [63:0] sb_q[$];
  logic [63:0] m_last;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_addr_echo(mem_addr_echo),
    .mem_read_valid(mem_read_valid), .mem_ready(mem_ready),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'h3701_0080;
      32'h0000_0004: rom_word = 32'h9300_1002;
      32'h0000_0008: rom_word = 32'h9300_2002;
      32'h0000_0024: rom_word = 32'h8320_0100;
      default:       rom_word = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Combinational ROM that echoes the requested address unless overridden.
  always_comb begin
    mem_data      = rom_word(mem_addr);
    mem_addr_echo = echo_ovr ? echo_val : mem_addr;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One clock: decide from the model state before the edge, update after it.
  task automatic tick();
    logic pp, sp, acc;
    @(negedge clk);
    pp  = (m_buf.size() != 0) && inst_ready;
    sp  = (m_buf.size() < DEPTH) || pp;
    acc = fetch_en && mem_ready && mem_read_valid &&
          ({mem_addr_echo[31:2], 2'b00} == m_pc) && sp && !redirect_valid;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = RESET_PC;
      m_buf.delete();
      sb_q.delete();
      m_last = '0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_buf.delete();
      sb_q.delete();
    end else begin
      if (pp) void'(m_buf.pop_front());
      if (acc) begin
        m_buf.push_back({m_pc, rom_word(m_pc)});
        sb_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (m_buf.size() != 0) m_last = m_buf[0];
    end
  endtask

  // Monitor: checks address, buffer head and each handshake against the scoreboard.
  always @(negedge clk) begin
    logic [63:0] ent;
    if (mon_en) begin
      chk("mem_addr", mem_addr, m_pc);
      chk("inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        chk("head_pc", inst_pc, m_buf[0][63:32]);
        chk("head_data", inst_data, m_buf[0][31:0]);
      end else begin
        chk("hold_pc", inst_pc, m_last[63:32]);
        chk("hold_data", inst_data, m_last[31:0]);
      end
      if (inst_valid && inst_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow actual=handshake expected=none at %0t", $time);
        end else begin
          ent = sb_q.pop_front();
          chk("pop_pc", inst_pc, ent[63:32]);
          chk("pop_data", inst_data, ent[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_read_valid = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1;
    echo_ovr = 1'b0; echo_val = '0;

    // Streaming from reset at full throughput.
    do_reset();
    mon_en = 1'b1;
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_addr", mem_addr, RESET_PC);
    repeat (6) tick();

    // Stalled decode fills exactly DEPTH entries, then drains in order.
    do_reset();
    inst_ready = 1'b0;
    repeat (5) tick();
    chk("full_addr", mem_addr, 32'h8);
    chk("full_head_pc", inst_pc, 32'h0);
    chk("full_head_data", inst_data, 32'h3701_0080);
    inst_ready = 1'b1;
    repeat (4) tick();

    // Redirect while full.
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h26;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", mem_addr, 32'h24);
    tick();
    chk("redir_head_pc", inst_pc, 32'h24);
    chk("redir_head_data", inst_data, 32'h8320_0100);
    inst_ready = 1'b1;
    repeat (3) tick();

    // Stale echo blocks fills until the echo matches again.
    do_reset();
    repeat (2) tick();
    echo_ovr = 1'b1; echo_val = 32'h10;
    repeat (4) tick();
    chk("stale_addr", mem_addr, 32'h8);
    chk("stale_valid", 32'(inst_valid), 32'd0);
    echo_ovr = 1'b0;
    repeat (3) tick();

    // fetch_en=0 with one entry buffered: drain only.
    do_reset();
    inst_ready = 1'b0;
    tick();
    fetch_en = 1'b0; inst_ready = 1'b1;
    repeat (3) tick();
    chk("noen_addr", mem_addr, 32'h4);
    chk("noen_valid", 32'(inst_valid), 32'd0);
    fetch_en = 1'b1;

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_target", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", mem_addr, 32'h0);
    repeat (2) tick();

    // Reset while full discards everything.
    inst_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_full_valid", 32'(inst_valid), 32'd0);
    chk("rst_full_addr", mem_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      fetch_en       = ($urandom_range(0, 7) != 0);
      mem_ready      = ($urandom_range(0, 3) != 0);
      mem_read_valid = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      echo_ovr       = ($urandom_range(0, 9) == 0);
      echo_val       = ($urandom_range(0, 1) == 0) ? $urandom() : mem_addr + 32'd4;
      tick();
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM's port A.
- Owns the fetch PC and drives the ROM read address.
- Captures returned words whose echoed address matches the expected PC into a small in-order buffer.
- Presents {pc, instruction} to decode over a valid/ready handshake; a redirect from execute flushes the buffer and restarts fetch at a new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  1 = allow new buffer fills; 0 = hold fetch PC, drain only.
- redirect_valid  input  1  1 = flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] are forced to 00 internally.
- mem_addr  output  32  ROM read address (the current fetch PC).
- mem_data  input  32  ROM read data.
- mem_addr_echo  input  32  address associated with mem_data.
- mem_read_valid  input  1  mem_data/mem_addr_echo are valid this cycle.
- mem_ready  input  1  ROM can accept an address.
- inst_valid  output  1  buffer head is valid.
- inst_data  output  32  instruction word at the buffer head.
- inst_pc  output  32  PC of inst_data.
- inst_ready  input  1  decode consumes the head this cycle.

Behaviour:
- Reset (rst=1 at an edge), regardless of any other input:
  - fetch_pc = RESET_PC; buffer emptied (count=0, read/write pointers 0).
  - inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-stream discards all buffered entries.
- mem_addr = fetch_pc, combinationally from the register, at all times (including during rst).
- Definitions, all evaluated in the current cycle:
  - pop = inst_valid & inst_ready.
  - space = (count < DEPTH) | pop. A full buffer accepts a fill when it pops in the same cycle.
  - accept = fetch_en & mem_ready & mem_read_valid & ({mem_addr_echo[31:2],2'b00} == fetch_pc) & space & ~redirect_valid.
- Accept cycle: write {fetch_pc, mem_data} at the write pointer; fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Response whose echo address does not match fetch_pc: dropped, no state change. This discards stale data after a redirect.
- Pop: read pointer advances.
- count update: count <= count + accept - pop. Width is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Buffer outputs are registered:
  - inst_valid = (count != 0).
  - inst_data and inst_pc reflect the head entry.
  - When the buffer is empty, inst_data and inst_pc hold their last values.
- Latency: with a combinational ROM, a word accepted in cycle N appears on inst_valid/inst_data in cycle N+1. There is no bypass from mem_data to inst_data.
- Throughput: one instruction per cycle when inst_ready is held high.
- redirect_valid=1 at an edge (rst=0):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; buffer flushed (count=0).
  - Any pop or accept in that cycle is ignored.
  - Next cycle: inst_valid=0 and mem_addr = redirect target.
  - redirect_valid has priority over fetch_en and the buffer state.
- fetch_en=0: no accepts; fetch_pc holds; buffered entries still drain to decode.
- mem_ready=0 or mem_read_valid=0: no accept; fetch_pc holds.
- inst_valid/inst_data/inst_pc must stay stable while inst_valid=1 and inst_ready=0.
- Not modelled: misaligned-fetch exceptions and branch prediction.

Test Plan:
- Reset release into the ROM image with fetch_en=1, inst_ready=1 -> inst_valid rises the cycle after the first accept; head reads (pc 0x0, 0x37010080); then (0x4, 0x93001002), (0x8, 0x93002002) on consecutive cycles; mem_addr steps 0, 4, 8, 0xC.
- inst_ready=0 from reset -> exactly DEPTH=2 entries fill; mem_addr holds at 0x8; head holds (0x0, 0x37010080). Raise inst_ready -> drains in order; a fill occurs in the same cycle as the first pop.
- Redirect to 0x26 while the buffer holds 2 entries -> next cycle inst_valid=0 and mem_addr=0x24; the cycle after, head is (0x24, 0x83200100).
- Stale response: tie mem_addr_echo to 0x10 while fetch_pc=0x8 -> no accept, no inst_valid rise; restore echo -> the fill resumes at 0x8.
- fetch_en=0 with 1 entry buffered, inst_ready=1 -> entry pops, inst_valid falls, mem_addr frozen. Wrap case: redirect to 0xFFFF_FFFC with an echoing memory model -> after one accept, mem_addr=0x0.
- Assert rst while the buffer is full -> next cycle inst_valid=0, mem_addr=RESET_PC.
